// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared memory-interface constants for the I/D memory arbiter
package memory_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_I = 2'd1;
  localparam logic [1:0] ST_WAIT_D = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant selection between fetch and data requesters
module mem_arb_pick
  import memory_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_last_grant,
  output logic o_grant_d
);

  logic w_tie_to_d;

  // Fixed priority hands every tie to D; round robin hands it to whoever was not served last.
  assign w_tie_to_d = (ROUND_ROBIN != 0) ? (i_last_grant == PORT_I) : 1'b1;
  assign o_grant_d  = i_req_d && (!i_req_i || w_tie_to_d);

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - arbitrates fetch and load/store ports onto one shared memory port
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_start,
  output logic        i_cmd_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  logic [1:0] r_state;
  logic       r_last_grant;
  logic       w_grant_d;
  logic       w_idle;
  logic       w_start;
  logic       w_accept;
  logic       w_wait_i;
  logic       w_wait_d;

  mem_arb_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .i_req_i      (i_cmd_start),
    .i_req_d      (d_cmd_start),
    .i_last_grant (r_last_grant),
    .o_grant_d    (w_grant_d)
  );

  // Gating with rst keeps every handshake output quiet while reset is held.
  assign w_idle   = !rst && (r_state == ST_IDLE);
  assign w_wait_i = !rst && (r_state == ST_WAIT_I);
  assign w_wait_d = !rst && (r_state == ST_WAIT_D);
  assign w_start  = w_idle && (i_cmd_start || d_cmd_start);
  assign w_accept = w_start && mem_cmd_ready;

  assign mem_cmd_start = w_start;
  assign mem_cmd_write = w_start && w_grant_d && d_cmd_write;
  assign mem_addr      = w_grant_d ? d_addr : i_addr;
  assign mem_wdata     = w_grant_d ? d_wdata : 32'd0;
  assign mem_wmask     = w_grant_d ? d_wmask : 32'd0;

  assign i_cmd_ready = w_start && !w_grant_d && mem_cmd_ready;
  assign d_cmd_ready = w_start && w_grant_d && mem_cmd_ready;

  assign i_rdata_valid = w_wait_i && mem_rdata_valid;
  assign d_rdata_valid = w_wait_d && mem_rdata_valid;
  assign i_rdata       = i_rdata_valid ? mem_rdata : 32'd0;
  assign d_rdata       = d_rdata_valid ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_I;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant_d ? PORT_D : PORT_I;
            // Stores finish on acceptance, so only reads leave IDLE.
            if (!(w_grant_d && d_cmd_write)) begin
              r_state <= w_grant_d ? ST_WAIT_D : ST_WAIT_I;
            end
          end
        end
        ST_WAIT_I, ST_WAIT_D: begin
          if (mem_rdata_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter
module tb_memory_arbiter;

  typedef struct {
    logic        port_d;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } acc_t;

  typedef struct {
    logic        port_d;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_start, d_cmd_start, d_cmd_write, mem_cmd_ready, mem_rdata_valid;
  logic [31:0] i_addr, d_addr, d_wdata, d_wmask, mem_rdata;
  logic        i_cmd_ready, d_cmd_ready, i_rdata_valid, d_rdata_valid;
  logic        mem_cmd_start, mem_cmd_write;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_wmask;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;

  memory_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cmd_start     (i_cmd_start),
    .i_cmd_ready     (i_cmd_ready),
    .i_addr          (i_addr),
    .i_rdata         (i_rdata),
    .i_rdata_valid   (i_rdata_valid),
    .d_cmd_start     (d_cmd_start),
    .d_cmd_write     (d_cmd_write),
    .d_cmd_ready     (d_cmd_ready),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_wmask         (d_wmask),
    .d_rdata         (d_rdata),
    .d_rdata_valid   (d_rdata_valid),
    .mem_cmd_start   (mem_cmd_start),
    .mem_cmd_write   (mem_cmd_write),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wmask       (mem_wmask),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_acc(input logic port_d, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [31:0] wmask);
    acc_t a;
    a.port_d = port_d; a.addr = addr; a.wr = wr; a.wdata = wdata; a.wmask = wmask;
    acc_q.push_back(a);
  endtask

  task automatic exp_rsp(input logic port_d, input logic [31:0] data);
    rsp_t r;
    r.port_d = port_d; r.data = data;
    rsp_q.push_back(r);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (mem_cmd_start && mem_cmd_ready) begin
      if (acc_q.size() == 0) begin
        check("unexpected_accept", 32'd1, 32'd0);
      end else begin
        acc_t a;
        a = acc_q.pop_front();
        check("acc_addr", mem_addr, a.addr);
        check("acc_write", {31'd0, mem_cmd_write}, {31'd0, a.wr});
        check("acc_wdata", mem_wdata, a.wdata);
        check("acc_wmask", mem_wmask, a.wmask);
        check("acc_ready_id", {30'd0, d_cmd_ready, i_cmd_ready}, {30'd0, a.port_d, !a.port_d});
      end
    end
    if (i_rdata_valid || d_rdata_valid) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rdata_valid", 32'd1, 32'd0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_valid_id", {30'd0, d_rdata_valid, i_rdata_valid}, {30'd0, r.port_d, !r.port_d});
        check("rsp_i_rdata", i_rdata, r.port_d ? 32'd0 : r.data);
        check("rsp_d_rdata", d_rdata, r.port_d ? r.data : 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_cmd_start = 0; d_cmd_start = 0; d_cmd_write = 0; mem_cmd_ready = 1; mem_rdata_valid = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wmask = 0; mem_rdata = 0;
    cyc(); cyc();

    // Reset holds all handshakes low even with requests and a response present.
    i_cmd_start = 1; d_cmd_start = 1; mem_rdata_valid = 1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("rst_mem_cmd_start", {31'd0, mem_cmd_start}, 32'd0);
    check("rst_cmd_ready", {30'd0, i_cmd_ready, d_cmd_ready}, 32'd0);
    check("rst_rdata_valid", {30'd0, i_rdata_valid, d_rdata_valid}, 32'd0);
    i_cmd_start = 0; d_cmd_start = 0; mem_rdata_valid = 0;
    cyc();
    rst = 1'b0;

    // Fetch-only read, response two cycles after acceptance.
    i_cmd_start = 1; i_addr = 32'h100;
    exp_acc(1'b0, 32'h100, 1'b0, 32'd0, 32'd0);
    cyc();
    i_cmd_start = 0;
    cyc();
    mem_rdata_valid = 1; mem_rdata = 32'hDEAD_BEEF;
    exp_rsp(1'b0, 32'hDEAD_BEEF);
    cyc();
    mem_rdata_valid = 0;

    // Tie after reset: D first, then I after the one-cycle bubble.
    rst = 1; cyc(); rst = 0;
    i_cmd_start = 1; i_addr = 32'h300;
    d_cmd_start = 1; d_addr = 32'h400; d_cmd_write = 0; d_wdata = 32'h1; d_wmask = 32'hF;
    exp_acc(1'b1, 32'h400, 1'b0, 32'h1, 32'hF);
    cyc();
    d_cmd_start = 0;
    #1;
    check("wait_d_no_start", {31'd0, mem_cmd_start}, 32'd0);
    check("wait_d_i_ready", {31'd0, i_cmd_ready}, 32'd0);
    mem_rdata_valid = 1; mem_rdata = 32'h1111_2222;
    exp_rsp(1'b1, 32'h1111_2222);
    #1;
    check("bubble_no_start", {31'd0, mem_cmd_start}, 32'd0);
    cyc();
    mem_rdata_valid = 0;
    exp_acc(1'b0, 32'h300, 1'b0, 32'd0, 32'd0);
    cyc();
    i_cmd_start = 0;
    mem_rdata_valid = 1; mem_rdata = 32'h3333_4444;
    exp_rsp(1'b0, 32'h3333_4444);
    cyc();
    mem_rdata_valid = 0;

    // Three back-to-back stores.
    d_cmd_start = 1; d_cmd_write = 1; d_wmask = 32'hFF;
    for (int k = 0; k < 3; k++) begin
      d_addr = 32'h200 + 32'(4 * k);
      d_wdata = 32'hA000_0000 + 32'(k);
      exp_acc(1'b1, d_addr, 1'b1, d_wdata, 32'hFF);
      cyc();
    end
    d_cmd_start = 0; d_cmd_write = 0;

    // Stray response in IDLE is ignored.
    mem_rdata_valid = 1; mem_rdata = 32'h7777_7777;
    #1;
    check("idle_rdata_ignored", {30'd0, i_rdata_valid, d_rdata_valid}, 32'd0);
    cyc();
    mem_rdata_valid = 0;

    // Backpressure for four cycles, accepted on the fifth.
    d_cmd_start = 1; d_addr = 32'h500; d_wdata = 32'h0; d_wmask = 32'h0; mem_cmd_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_d_ready", {31'd0, d_cmd_ready}, 32'd0);
      check("bp_i_ready", {31'd0, i_cmd_ready}, 32'd0);
      check("bp_start", {31'd0, mem_cmd_start}, 32'd1);
      cyc();
    end
    mem_cmd_ready = 1;
    exp_acc(1'b1, 32'h500, 1'b0, 32'h0, 32'h0);
    cyc();
    d_cmd_start = 0;

    // Reset while the load is outstanding; the late response is dropped.
    rst = 1; cyc(); rst = 0;
    mem_rdata_valid = 1; mem_rdata = 32'h9999_9999;
    #1;
    check("late_rsp_dropped", {30'd0, i_rdata_valid, d_rdata_valid}, 32'd0);
    cyc();
    mem_rdata_valid = 0;
    d_cmd_start = 1; d_addr = 32'h600;
    exp_acc(1'b1, 32'h600, 1'b0, 32'h0, 32'h0);
    cyc();
    d_cmd_start = 0;
    mem_rdata_valid = 1; mem_rdata = 32'hCAFE_F00D;
    exp_rsp(1'b1, 32'hCAFE_F00D);
    cyc();
    mem_rdata_valid = 0;
    cyc(); cyc();

    check("acc_q_drained", acc_q.size(), 32'd0);
    check("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: ROUND_ROBIN, default 1; 1 = tie goes to the requester not granted last, 0 = data port always wins ties.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 i_cmd_start  input  1  instruction-fetch read request.
REQ-006 i_cmd_ready  output  1  instruction request accepted this cycle.
REQ-007 i_addr  input  32  fetch address.
REQ-008 i_rdata  output  32  fetch read data; valid only with i_rdata_valid.
REQ-009 i_rdata_valid  output  1  fetch read data valid.
REQ-010 d_cmd_start  input  1  memory-stage request.
REQ-011 d_cmd_write  input  1  memory-stage request is a store.
REQ-012 d_cmd_ready  output  1  memory-stage request accepted this cycle.
REQ-013 d_addr, d_wdata, d_wmask  input  32 each  store/load address, write data, byte-lane mask.
REQ-014 d_rdata  output  32  load data; valid only with d_rdata_valid.
REQ-015 d_rdata_valid  output  1  load data valid.
REQ-016 mem_cmd_start, mem_cmd_write  output  1 each  request and store flag to the shared memory.
REQ-017 mem_cmd_ready  input  1  memory accepts the request this cycle.
REQ-018 mem_addr, mem_wdata, mem_wmask  output  32 each  muxed from the granted port.
REQ-019 mem_rdata  input  32; mem_rdata_valid  input  1  read response.

Function
REQ-020 States: IDLE, WAIT_I (fetch read outstanding), WAIT_D (load outstanding); at most one read outstanding.
REQ-021 IDLE: grant = the sole requester; on a tie, grant the port not in last_grant (ROUND_ROBIN=1) or D (ROUND_ROBIN=0).
REQ-022 IDLE: mem_cmd_* and mem_addr/wdata/wmask SHALL follow the granted port combinationally; with the I port granted, mem_cmd_write=0 and mem_wdata/mem_wmask=0.
REQ-023 The granted port's cmd_ready SHALL equal mem_cmd_ready; the ungranted port's cmd_ready SHALL be 0.
REQ-024 Acceptance = mem_cmd_start && mem_cmd_ready; last_grant SHALL update to the accepted port on acceptance.
REQ-025 An accepted store completes on acceptance; the state SHALL remain IDLE, so back-to-back stores are accepted on consecutive cycles.
REQ-026 An accepted read SHALL move the state to WAIT_I or WAIT_D on the next edge.
REQ-027 WAIT_x: mem_cmd_start=0 and both cmd_ready=0; x_rdata_valid SHALL equal mem_rdata_valid, with x_rdata = mem_rdata, same cycle (0 added latency).
REQ-028 WAIT_x with mem_rdata_valid=1: return to IDLE; no new request is accepted in that cycle (one-cycle bubble).
REQ-029 mem_rdata_valid in IDLE SHALL be ignored, with both rdata_valid=0.
REQ-030 A requester dropping cmd_start before acceptance SHALL leave the grant re-evaluated next cycle with no state change.
REQ-031 Non-selected rdata outputs SHALL be 0.

Reset
REQ-032 When rst=1 at the clock edge: state=IDLE, last_grant=I; while rst=1, all cmd_ready, rdata_valid and mem_cmd_start SHALL be 0.
REQ-033 A reset during WAIT_x SHALL discard the outstanding read; a late mem_rdata_valid after reset is ignored per REQ-029.

Structure
REQ-034 State encoding and port-ID constants SHALL live in the shared memory-interface include/package alongside the existing MEN_*/WB_* constants.
REQ-035 One sub-module, mem_arb_pick (tie-break/grant logic), is natural; everything else stays in memory_arbiter.

Verification
REQ-036 Fetch read only: i_cmd_start=1, i_addr=0x100, ready=1; memory returns valid 2 cycles later with 0xDEADBEEF -> i_rdata_valid=1 with i_rdata=0xDEADBEEF, d_rdata_valid=0.
REQ-037 Tie, ROUND_ROBIN=1, after reset: both ports request reads -> D granted first (mem_addr=d_addr); after its response, I granted next.
REQ-038 Store stream: d_cmd_write=1 for 3 cycles with ready=1, addr 0x200/0x204/0x208, wmask 0xFF -> three consecutive acceptances; state stays IDLE; no rdata_valid.
REQ-039 Backpressure: mem_cmd_ready=0 for 4 cycles while D requests -> d_cmd_ready=0, i_cmd_ready=0; accepted on cycle 5.
REQ-040 Reset in WAIT_D: rst pulsed one cycle, then mem_rdata_valid=1 -> d_rdata_valid=0; the next request is accepted normally.
